// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and width limits for the counter and its converters.
package gray_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  typedef logic [MAX_WIDTH-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter, reused by CDC synchronisers.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Zero-extension keeps the upper prefix-XOR bits at 0, so truncation is exact.
  assign bin = WIDTH'(gray2bin(word_t'(gray)));

endmodule

// File: rtl/gray_counter_ud.sv
// Up/down counter with registered binary and Gray views updated on the same edge,
// synchronous load, wrap-or-saturate limits, limit flags and a one-cycle wrap pulse.
module gray_counter_ud
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter bit SATURATE    = 1'b0,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_gray,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("gray_counter_ud: WIDTH out of range");
  end

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;

  always_comb begin
    bin_nxt  = count_bin;
    wrap_nxt = 1'b0;
    if (load) begin
      bin_nxt = load_value;
    end else if (enable) begin
      if (up) begin
        if (count_bin == ALL_ONES) begin
          if (!SATURATE) begin
            bin_nxt  = '0;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = count_bin + 1'b1;
        end
      end else begin
        if (count_bin == '0) begin
          if (!SATURATE) begin
            bin_nxt  = ALL_ONES;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = count_bin - 1'b1;
        end
      end
    end
  end

  // Gray is derived from the next binary value so both registers agree every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_bin  <= RST_BIN;
      count_gray <= RST_GRAY;
      wrap       <= 1'b0;
    end else begin
      count_bin  <= bin_nxt;
      count_gray <= WIDTH'(bin2gray(word_t'(bin_nxt)));
      wrap       <= wrap_nxt;
    end
  end

  assign at_max = &count_bin;
  assign at_min = ~|count_bin;

endmodule

// File: tb/tb_gray_counter_ud.sv
// Directed table plus corner-case sequences and a randomised reference-model run.
module tb_gray_counter_ud;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the 4-bit instances
  logic       reset = 1'b0, enable = 1'b0, up = 1'b0, load = 1'b0;
  logic [3:0] load_value = '0;

  logic [3:0] w_bin, w_gray, r_bin, r_gray, s_bin, s_gray;
  logic       w_max, w_min, w_wrap, r_max, r_min, r_wrap, s_max, s_min, s_wrap;

  logic       reset6 = 1'b0, enable6 = 1'b0, up6 = 1'b0, load6 = 1'b0;
  logic [5:0] load_value6 = '0;
  logic [5:0] b6, g6, conv6;
  logic       max6, min6, wrap6;

  gray_counter_ud #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .count_bin(w_bin), .count_gray(w_gray),
    .at_max(w_max), .at_min(w_min), .wrap(w_wrap));

  gray_counter_ud #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(5)) u_rv5 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .count_bin(r_bin), .count_gray(r_gray),
    .at_max(r_max), .at_min(r_min), .wrap(r_wrap));

  gray_counter_ud #(.WIDTH(4), .SATURATE(1'b1), .RESET_VALUE(0)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .count_bin(s_bin), .count_gray(s_gray),
    .at_max(s_max), .at_min(s_min), .wrap(s_wrap));

  gray_counter_ud #(.WIDTH(6), .SATURATE(1'b0), .RESET_VALUE(0)) u_w6 (
    .clk(clk), .reset(reset6), .enable(enable6), .up(up6), .load(load6),
    .load_value(load_value6), .count_bin(b6), .count_gray(g6),
    .at_max(max6), .at_min(min6), .wrap(wrap6));

  gray_to_bin #(.WIDTH(6)) u_conv6 (.gray(g6), .bin(conv6));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic [3:0] lv,
                       input logic e, input logic u);
    reset = r; load = l; load_value = lv; enable = e; up = u;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r, l;
    logic [3:0] lv;
    logic       e, u;
    logic [3:0] bin, gray;
    logic       wrap, mx, mn;
  } vec_t;

  vec_t vecs[16];

  int         ref6;
  logic       wrap_ref6;
  logic [5:0] exp_g6;
  logic [3:0] prev_gray;

  initial begin
    //          r  l  lv     e  u  bin     gray      wrap max min
    vecs[0]  = '{1, 0, 4'd0, 0, 0, 4'd0,  4'b0000, 0, 0, 1};
    vecs[1]  = '{0, 1, 4'd9, 1, 1, 4'd9,  4'b1101, 0, 0, 0};
    vecs[2]  = '{0, 0, 4'd0, 1, 1, 4'd10, 4'b1111, 0, 0, 0};
    vecs[3]  = '{0, 1, 4'd14,0, 0, 4'd14, 4'b1001, 0, 0, 0};
    vecs[4]  = '{0, 0, 4'd0, 1, 1, 4'd15, 4'b1000, 0, 1, 0};
    vecs[5]  = '{0, 0, 4'd0, 1, 1, 4'd0,  4'b0000, 1, 0, 1};
    vecs[6]  = '{0, 0, 4'd0, 0, 1, 4'd0,  4'b0000, 0, 0, 1};
    vecs[7]  = '{0, 0, 4'd0, 1, 0, 4'd15, 4'b1000, 1, 1, 0};
    vecs[8]  = '{0, 0, 4'd0, 1, 1, 4'd0,  4'b0000, 1, 0, 1};
    vecs[9]  = '{1, 1, 4'd9, 1, 1, 4'd0,  4'b0000, 0, 0, 1};
    vecs[10] = '{0, 0, 4'd0, 1, 0, 4'd15, 4'b1000, 1, 1, 0};
    vecs[11] = '{1, 0, 4'd0, 1, 0, 4'd0,  4'b0000, 0, 0, 1};
    vecs[12] = '{0, 1, 4'd3, 0, 0, 4'd3,  4'b0010, 0, 0, 0};
    vecs[13] = '{0, 0, 4'd0, 1, 0, 4'd2,  4'b0011, 0, 0, 0};
    vecs[14] = '{0, 0, 4'd0, 1, 0, 4'd1,  4'b0001, 0, 0, 0};
    vecs[15] = '{0, 0, 4'd0, 1, 0, 4'd0,  4'b0000, 0, 0, 1};

    reset6 = 1'b1;

    // RESET_VALUE = 5 instance
    drive(1, 0, 4'd0, 0, 0);
    chk("rv5_reset_bin",  r_bin,  5);
    chk("rv5_reset_gray", r_gray, 4'b0111);
    chk("rv5_reset_wrap", r_wrap, 0);
    chk("rv5_reset_max",  r_max,  0);
    chk("rv5_reset_min",  r_min,  0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].r, vecs[i].l, vecs[i].lv, vecs[i].e, vecs[i].u);
      chk($sformatf("vec%0d_bin",  i), w_bin,  vecs[i].bin);
      chk($sformatf("vec%0d_gray", i), w_gray, vecs[i].gray);
      chk($sformatf("vec%0d_wrap", i), w_wrap, vecs[i].wrap);
      chk($sformatf("vec%0d_max",  i), w_max,  vecs[i].mx);
      chk($sformatf("vec%0d_min",  i), w_min,  vecs[i].mn);
    end

    // 17 up steps from 0 across the wrap
    drive(1, 0, 4'd0, 0, 0);
    prev_gray = w_gray;
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 4'd0, 1, 1);
      chk($sformatf("up%0d_bin", i), w_bin, (i + 1) % 16);
      chk($sformatf("up%0d_wrap", i), w_wrap, (i == 15) ? 1 : 0);
      chk($sformatf("up%0d_gray_bits", i), $countones(w_gray ^ prev_gray), 1);
      prev_gray = w_gray;
    end

    // Down step from 0, then hold clears the pulse
    drive(1, 0, 4'd0, 0, 0);
    drive(0, 0, 4'd0, 1, 0);
    chk("down_bin",  w_bin,  15);
    chk("down_gray", w_gray, 4'b1000);
    chk("down_wrap", w_wrap, 1);
    chk("down_max",  w_max,  1);
    drive(0, 0, 4'd0, 0, 0);
    chk("down_hold_wrap", w_wrap, 0);
    chk("down_hold_bin",  w_bin,  15);

    // Reset beats load and enable on a non-zero RESET_VALUE
    drive(0, 1, 4'd9, 1, 1);
    chk("rv5_load_bin", r_bin, 9);
    drive(1, 1, 4'd9, 1, 1);
    chk("rv5_reset_load_bin",  r_bin,  5);
    chk("rv5_reset_load_gray", r_gray, 4'b0111);

    // Saturating instance
    drive(1, 0, 4'd0, 0, 0);
    drive(0, 1, 4'd14, 0, 0);
    chk("sat_load_bin", s_bin, 14);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4'd0, 1, 1);
      chk($sformatf("sat_up%0d_bin", i), s_bin, 15);
      chk($sformatf("sat_up%0d_wrap", i), s_wrap, 0);
    end
    chk("sat_top_max", s_max, 1);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 4'd0, 1, 0);
      chk($sformatf("sat_dn%0d_bin", i), s_bin, (15 - i < 0) ? 0 : 15 - i);
      chk($sformatf("sat_dn%0d_wrap", i), s_wrap, 0);
    end
    chk("sat_bottom_min", s_min, 1);
    chk("sat_bottom_gray", s_gray, 0);

    // Randomised 6-bit run against a reference model
    drive(0, 0, 4'd0, 0, 0);
    ref6 = 0;
    for (int c = 0; c < 10000; c++) begin
      reset6      = ($urandom_range(0, 199) == 0);
      load6       = ($urandom_range(0, 19) == 0);
      load_value6 = 6'($urandom);
      enable6     = ($urandom_range(0, 3) != 0);
      up6         = $urandom_range(0, 1) == 1;
      wrap_ref6   = 1'b0;
      if (reset6) ref6 = 0;
      else if (load6) ref6 = load_value6;
      else if (enable6) begin
        if (up6) begin
          wrap_ref6 = (ref6 == 63);
          ref6 = (ref6 + 1) % 64;
        end else begin
          wrap_ref6 = (ref6 == 0);
          ref6 = (ref6 + 63) % 64;
        end
      end
      @(posedge clk);
      #1;
      exp_g6 = 6'(ref6) ^ (6'(ref6) >> 1);
      chk($sformatf("rnd%0d_bin", c), b6, ref6);
      chk($sformatf("rnd%0d_gray", c), g6, exp_g6);
      chk($sformatf("rnd%0d_conv", c), conv6, b6);
      chk($sformatf("rnd%0d_wrap", c), wrap6, wrap_ref6);
      chk($sformatf("rnd%0d_min", c), min6, (ref6 == 0) ? 1 : 0);
      chk($sformatf("rnd%0d_max", c), max6, (ref6 == 63) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
